// File: rtl/key_pkg.sv
// Shared definitions for the key debounce bank: per-key FSM state encoding
// and the debounce counter width helper.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_e;

    // Wide enough to hold DEBOUNCE_CYCLES itself, so the counter never wraps.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key: synchroniser, debounce counter FSM, clean level and 1-cycle press/release strobes.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 edges from the first sample of a stable level; no backpressure.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pressed_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    key_state_e             state_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;

    // Only the last synchroniser stage is allowed to reach the FSM.
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pressed_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= PRESS_CHK;
                        cnt_q   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!s) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_q <= RELEASE_CHK;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (s) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debounce_bank.sv
// N independent debounced key channels with pin-polarity normalisation (internal 1 = pressed).
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 edges per channel; no backpressure, strobes are fire-and-forget.
module key_debounce_bank #(
    parameter int N_KEYS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    logic [N_KEYS-1:0] pressed;

    // Inverted ahead of the synchroniser so reset's 0 always means 'released'.
    assign pressed = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .pressed_i (pressed[k]),
            .level_o   (key_level[k]),
            .press_o   (key_press[k]),
            .release_o (key_release[k])
        );
    end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Bench for key_debounce_bank (2 keys, 2 sync stages, 4 debounce cycles, active-low pins).
// Expected per-edge outputs are queued as stimulus is driven and compared after the run of each scenario.
module tb_key_debounce_bank;

    logic       clk;
    logic       rst;
    logic [1:0] key_raw;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;

    typedef struct {
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        int         cyc;
    } smp_t;

    smp_t exp_q[$];
    smp_t obs_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    key_debounce_bank #(
        .N_KEYS          (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs, queue what that edge must produce, record what it did produce.
    task automatic drive_cycle(input logic r, input logic [1:0] raw,
                               input logic [1:0] lvl, input logic [1:0] prs, input logic [1:0] rel);
        smp_t e;
        smp_t o;
        rst     = r;
        key_raw = raw;
        cyc++;
        e.lvl = lvl; e.prs = prs; e.rel = rel; e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.lvl = key_level; o.prs = key_press; o.rel = key_release; o.cyc = cyc;
        obs_q.push_back(o);
    endtask

    // Hold raw for n edges; the level switches and the strobes fire at phase edge chg (1-based).
    task automatic drive_phase(input logic [1:0] raw, input int n,
                               input logic [1:0] lvl_a, input logic [1:0] lvl_b, input int chg,
                               input logic [1:0] prs, input logic [1:0] rel);
        for (int e = 1; e <= n; e++) begin
            drive_cycle(1'b0, raw, (e >= chg) ? lvl_b : lvl_a,
                        (e == chg) ? prs : 2'b00, (e == chg) ? rel : 2'b00);
        end
    endtask

    task automatic test_reset();
        smp_t e;
        smp_t o;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        drive_phase(2'b00, 9, 2'b00, 2'b11, 7, 2'b11, 2'b00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.lvl !== e.lvl) begin bad++; $display("FAIL reset_level cyc=%0d got=%b want=%b", e.cyc, o.lvl, e.lvl); end
            total++;
            if (o.prs !== e.prs) begin bad++; $display("FAIL reset_press cyc=%0d got=%b want=%b", e.cyc, o.prs, e.prs); end
            total++;
            if (o.rel !== e.rel) begin bad++; $display("FAIL reset_release cyc=%0d got=%b want=%b", e.cyc, o.rel, e.rel); end
        end
    endtask

    task automatic test_clean();
        smp_t e;
        smp_t o;
        drive_phase(2'b11, 8, 2'b11, 2'b00, 7, 2'b00, 2'b11);
        drive_phase(2'b10, 8, 2'b00, 2'b01, 7, 2'b01, 2'b00);
        drive_phase(2'b11, 8, 2'b01, 2'b00, 7, 2'b00, 2'b01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.lvl !== e.lvl) begin bad++; $display("FAIL clean_level cyc=%0d got=%b want=%b", e.cyc, o.lvl, e.lvl); end
            total++;
            if (o.prs !== e.prs) begin bad++; $display("FAIL clean_press cyc=%0d got=%b want=%b", e.cyc, o.prs, e.prs); end
            total++;
            if (o.rel !== e.rel) begin bad++; $display("FAIL clean_release cyc=%0d got=%b want=%b", e.cyc, o.rel, e.rel); end
        end
    endtask

    task automatic test_bounce();
        smp_t e;
        smp_t o;
        drive_phase(2'b10, 3, 2'b00, 2'b00, 99, 2'b00, 2'b00);
        drive_phase(2'b11, 1, 2'b00, 2'b00, 99, 2'b00, 2'b00);
        drive_phase(2'b10, 9, 2'b00, 2'b01, 7, 2'b01, 2'b00);
        drive_phase(2'b11, 8, 2'b01, 2'b00, 7, 2'b00, 2'b01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.lvl !== e.lvl) begin bad++; $display("FAIL bounce_level cyc=%0d got=%b want=%b", e.cyc, o.lvl, e.lvl); end
            total++;
            if (o.prs !== e.prs) begin bad++; $display("FAIL bounce_press cyc=%0d got=%b want=%b", e.cyc, o.prs, e.prs); end
            total++;
            if (o.rel !== e.rel) begin bad++; $display("FAIL bounce_release cyc=%0d got=%b want=%b", e.cyc, o.rel, e.rel); end
        end
    endtask

    task automatic test_glitch();
        smp_t e;
        smp_t o;
        drive_phase(2'b01, 3, 2'b00, 2'b00, 99, 2'b00, 2'b00);
        drive_phase(2'b11, 8, 2'b00, 2'b00, 99, 2'b00, 2'b00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.lvl !== e.lvl) begin bad++; $display("FAIL glitch_level cyc=%0d got=%b want=%b", e.cyc, o.lvl, e.lvl); end
            total++;
            if (o.prs !== e.prs) begin bad++; $display("FAIL glitch_press cyc=%0d got=%b want=%b", e.cyc, o.prs, e.prs); end
            total++;
            if (o.rel !== e.rel) begin bad++; $display("FAIL glitch_release cyc=%0d got=%b want=%b", e.cyc, o.rel, e.rel); end
        end
    endtask

    task automatic test_reset_mid();
        smp_t e;
        smp_t o;
        drive_phase(2'b10, 4, 2'b00, 2'b00, 99, 2'b00, 2'b00);
        drive_cycle(1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
        drive_phase(2'b10, 9, 2'b00, 2'b01, 7, 2'b01, 2'b00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.lvl !== e.lvl) begin bad++; $display("FAIL rstmid_level cyc=%0d got=%b want=%b", e.cyc, o.lvl, e.lvl); end
            total++;
            if (o.prs !== e.prs) begin bad++; $display("FAIL rstmid_press cyc=%0d got=%b want=%b", e.cyc, o.prs, e.prs); end
            total++;
            if (o.rel !== e.rel) begin bad++; $display("FAIL rstmid_release cyc=%0d got=%b want=%b", e.cyc, o.rel, e.rel); end
        end
    endtask

    task automatic test_simultaneous();
        smp_t e;
        smp_t o;
        drive_phase(2'b11, 8, 2'b01, 2'b00, 7, 2'b00, 2'b01);
        drive_phase(2'b01, 8, 2'b00, 2'b10, 7, 2'b10, 2'b00);
        drive_phase(2'b10, 9, 2'b10, 2'b01, 7, 2'b01, 2'b10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o.lvl !== e.lvl) begin bad++; $display("FAIL simul_level cyc=%0d got=%b want=%b", e.cyc, o.lvl, e.lvl); end
            total++;
            if (o.prs !== e.prs) begin bad++; $display("FAIL simul_press cyc=%0d got=%b want=%b", e.cyc, o.prs, e.prs); end
            total++;
            if (o.rel !== e.rel) begin bad++; $display("FAIL simul_release cyc=%0d got=%b want=%b", e.cyc, o.rel, e.rel); end
        end
    endtask

    initial begin
        rst     = 1'b1;
        key_raw = 2'b11;
        test_reset();
        test_clean();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
